hazard_scoreboard: RTL
======================

// Module: hazard_scoreboard
// PURPOSE
//  Issue-gating controller for the ID->EX pipeline register. Tracks in-flight GPR writes in a
//  per-register pending counter and holds the ID stage on RAW hazards. Retires entries at
//  writeback or when EXU kills the EX-stage op. Also drives the flush controls for the
//  IF/ID and ID/EX registers on a branch or trap redirect.
// PARAMETERS
//  NREG   32  number of architectural GPRs; x0 is never tracked
//  RS_W   5   register index width, equal to $clog2(NREG)
//  CNT_W  2   width of each pending counter; CMAX = 2**CNT_W-1 in-flight writes per rd
// PORTS
//  clk_i         in   1      clock
//  rst_i         in   1      synchronous, active-high reset
//  d_valid_i     in   1      IDU holds a valid decoded op
//  E_ready_i     in   1      ID/EX register can accept an op
//  d_rs1_i       in   RS_W   source 1 index
//  d_rs1_en_i    in   1      op reads rs1
//  d_rs2_i       in   RS_W   source 2 index
//  d_rs2_en_i    in   1      op reads rs2
//  d_rd_i        in   RS_W   destination index
//  d_wenReg_i    in   1      op writes rd
//  w_valid_i     in   1      WB retires an op this cycle
//  w_wenReg_i    in   1      retiring op wrote a GPR
//  w_rd_i        in   RS_W   retiring op's rd
//  x_kill_i      in   1      EXU kills the op in ID/EX (its rd write is cancelled)
//  x_kill_wen_i  in   1      killed op had d_wenReg set
//  x_kill_rd_i   in   RS_W   killed op's rd
//  redirect_i    in   1      EXU redirects the PC (branch taken / trap)
//  d_stall_o     out  1      hazard: hold the IDU op
//  D_valid_o     out  1      gated valid into ID/EX: d_valid_i & ~d_stall_o & ~redirect_i
//  F_flush_o     out  1      clear IF/ID; equals redirect_i
//  D_flush_o     out  1      clear ID/EX; equals redirect_i
//  busy_o        out  1      any counter non-zero
//  err_o         out  1      sticky: a release hit a zero counter
// BEHAVIOUR
//  - Reset: all counters 0, err_o 0. Combinational outputs follow their inputs; with idle
//    inputs they reset to 0 (busy_o is 0).
//  - src hit:  rsN_en & rsN!=0 & cnt[rsN]!=0.
//  - WAW sat:  d_wenReg & rd!=0 & cnt[rd]==CMAX.
//  - d_stall_o = d_valid_i & (src1 hit | src2 hit | WAW sat). Combinational from the
//    registered counters. There is no same-cycle release bypass, so a release in cycle t
//    unblocks the op in cycle t+1.
//  - issue = D_valid_o & E_ready_i. Increment on issue & d_wenReg_i & d_rd_i!=0.
//  - rel_w = w_valid_i & w_wenReg_i & w_rd_i!=0. rel_k = x_kill_i & x_kill_wen_i & x_kill_rd_i!=0.
//  - Counter update, all in the same cycle: cnt[r] += inc(r) - rel_w(r) - rel_k(r). The
//    net change ranges from -2 to +1.
//  - Issue and release to the same rd in one cycle: the counter is unchanged.
//  - Underflow: the result clamps at 0 and err_o sets. err_o clears only on reset.
//  - Overflow cannot happen: an op that would take a counter past CMAX is stalled by WAW sat.
//  - redirect_i: suppresses issue in the same cycle (D_valid_o=0, no increment) and asserts
//    both flushes. The op already in ID/EX is released via x_kill_* in the same cycle, not
//    by this block.
//  - Reset mid-operation: counters clear. The pipe registers are reset by the same rst_i,
//    so no stale releases arrive afterwards.
//  - cnt[0] is hard-wired to 0.
// TESTING
//  1 rst; issue rd=5 -> cnt[5]=1, busy_o=1; next op rs1=5 -> d_stall_o=1 until the cycle after w_rd_i=5 retires
//  2 rs1=0 and rd=0 ops -> never stall, no count; 4 issues to rd=7 -> the 4th stalls (CMAX=3) until one release
//  3 issue rd=3 and w retire rd=3 in one cycle with cnt[3]=1 -> cnt stays 1; stall on rs2=3 is held
//  4 cnt[9]=2; w retire rd=9 + x_kill rd=9 together -> cnt[9]=0, stall drops next cycle
//  5 redirect_i with d_valid_i=1 & E_ready_i=1 -> D_valid_o=0, F_flush_o=D_flush_o=1, no increment
//  6 release rd=4 with cnt[4]=0 -> cnt[4]=0, err_o=1 sticky; assert rst_i with counters busy -> all 0 next cycle

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Issue-gating scoreboard for the ID->EX register: per-GPR pending-write counters, RAW/WAW-sat
// stall, release on writeback or EX kill, and redirect-driven flushes.
module hazard_scoreboard #(
  parameter int unsigned NREG  = 32,
  parameter int unsigned RS_W  = 5,
  parameter int unsigned CNT_W = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            d_valid_i,
  input  logic            E_ready_i,
  input  logic [RS_W-1:0] d_rs1_i,
  input  logic            d_rs1_en_i,
  input  logic [RS_W-1:0] d_rs2_i,
  input  logic            d_rs2_en_i,
  input  logic [RS_W-1:0] d_rd_i,
  input  logic            d_wenReg_i,
  input  logic            w_valid_i,
  input  logic            w_wenReg_i,
  input  logic [RS_W-1:0] w_rd_i,
  input  logic            x_kill_i,
  input  logic            x_kill_wen_i,
  input  logic [RS_W-1:0] x_kill_rd_i,
  input  logic            redirect_i,
  output logic            d_stall_o,
  output logic            D_valid_o,
  output logic            F_flush_o,
  output logic            D_flush_o,
  output logic            busy_o,
  output logic            err_o
);

  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic             err_q, err_d;
  logic             src1_hit, src2_hit, waw_sat;
  logic             inc_en, rel_w, rel_k;

  always_comb begin
    src1_hit  = d_rs1_en_i && (d_rs1_i != '0) && (cnt_q[d_rs1_i] != '0);
    src2_hit  = d_rs2_en_i && (d_rs2_i != '0) && (cnt_q[d_rs2_i] != '0);
    waw_sat   = d_wenReg_i && (d_rd_i != '0) && (cnt_q[d_rd_i] == CMAX);
    d_stall_o = d_valid_i && (src1_hit || src2_hit || waw_sat);
    D_valid_o = d_valid_i && !d_stall_o && !redirect_i;
    F_flush_o = redirect_i;
    D_flush_o = redirect_i;
    inc_en    = D_valid_o && E_ready_i && d_wenReg_i && (d_rd_i != '0);
    rel_w     = w_valid_i && w_wenReg_i && (w_rd_i != '0);
    rel_k     = x_kill_i && x_kill_wen_i && (x_kill_rd_i != '0);
  end

  // Widened by one bit so the net -2..+1 change can be compared before clamping at zero.
  always_comb begin
    logic [CNT_W:0] up;
    logic [CNT_W:0] dn;
    err_d = err_q;
    up    = '0;
    dn    = '0;
    for (int r = 0; r < int'(NREG); r++) begin
      up = {1'b0, cnt_q[r]} + {{CNT_W{1'b0}}, (inc_en && (d_rd_i == RS_W'(r)))};
      dn = {{CNT_W{1'b0}}, (rel_w && (w_rd_i == RS_W'(r)))} +
           {{CNT_W{1'b0}}, (rel_k && (x_kill_rd_i == RS_W'(r)))};
      if (r == 0) begin
        cnt_d[r] = '0;
      end else if (dn > up) begin
        cnt_d[r] = '0;
        err_d    = 1'b1;
      end else begin
        cnt_d[r] = CNT_W'(up - dn);
      end
    end
  end

  always_comb begin
    busy_o = 1'b0;
    for (int r = 0; r < int'(NREG); r++) begin
      busy_o = busy_o | (cnt_q[r] != '0);
    end
  end

  assign err_o = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < int'(NREG); r++) begin
        cnt_q[r] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

endmodule
